reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: ALU result path (alu_*) and load/memory result path (mem_*).
- Fixed priority to mem. A starvation counter forces an alu grant after MAX_WAIT consecutive lost contentions.
- The winning request is registered and driven onto reg_write / reg_write_dest / reg_write_data, which feed the 32x64 register file directly.
- Also suppresses writes to x0 and keeps write and conflict statistics.

Parameters:
- MAX_WAIT, 3, consecutive contended cycles alu may lose before it is forced to win; legal range 1..15.
- ZERO_REG_HARDWIRED, 1, when 1 a granted write to dest 0 is consumed but not written.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_hold  input  1  freeze: no grants while high
- alu_wr_valid  input  1  alu request
- alu_wr_dest  input  5  alu destination register
- alu_wr_data  input  64  alu write data
- alu_wr_ready  output  1  alu request granted this cycle (combinational)
- mem_wr_valid  input  1  mem request
- mem_wr_dest  input  5  mem destination register
- mem_wr_data  input  64  mem write data
- mem_wr_ready  output  1  mem request granted this cycle (combinational)
- reg_write  output  1  register file write enable (registered)
- reg_write_dest  output  5  register file write address (registered)
- reg_write_data  output  64  register file write data (registered)
- wb_count  output  16  performed writes, wraps
- conflict_count  output  16  cycles with both requests valid and wb_hold low, wraps

Behaviour:
- Reset (async assert, sync-free release): reg_write=0, reg_write_dest=0, reg_write_data=0, starve_cnt=0, wb_count=0, conflict_count=0. Asserting reset mid-transfer drops the pending output write; reg_write falls immediately.
- Requester rules:
  - dest and data must stay stable while valid is high and ready is low.
  - A request is consumed on a rising edge where valid && ready.
  - Valid may drop only after consumption.
- Grant logic (combinational, wb_hold=0):
  - force_alu = (starve_cnt == MAX_WAIT).
  - grant_alu = alu_wr_valid && (!mem_wr_valid || force_alu).
  - grant_mem = mem_wr_valid && !grant_alu.
  - alu_wr_ready = grant_alu; mem_wr_ready = grant_mem. Ready is never high without the matching valid.
- wb_hold=1: both readies 0; starve_cnt holds; conflict_count does not increment; reg_write=0 next cycle.
- Output stage, one-cycle latency:
  - On the edge that consumes a request: reg_write_dest and reg_write_data take the granted dest/data.
  - reg_write takes 1, except 0 when ZERO_REG_HARDWIRED=1 and dest==0.
  - With no grant: reg_write takes 0, and dest/data hold their previous values.
  - The register file writes on the following edge. Total request-to-written latency is 2 edges.
- Starvation counter (4 bits):
  - Both valid and mem granted: starve_cnt += 1, saturating at MAX_WAIT.
  - alu granted, or alu_wr_valid=0: starve_cnt = 0.
  - Otherwise it holds.
- Counters:
  - wb_count increments on each edge where reg_write is set to 1. Suppressed x0 writes do not count.
  - conflict_count increments on each edge where alu_wr_valid && mem_wr_valid && !wb_hold.
  - Both wrap 0xFFFF -> 0x0000.
- Simultaneous events:
  - Both valid with starve_cnt < MAX_WAIT: mem wins.
  - Both valid with starve_cnt == MAX_WAIT: alu wins.
  - A single valid requester always wins (unless wb_hold=1).
- Same-destination requests: no merging. Each is written in grant order, and the last write wins in the register file.

Test Plan:
- Reset mid-op:
  - Stimulus: grant alu dest 7 data 916, then pull reset_n low before the next edge.
  - Required: reg_write=0 and all counters 0 immediately. After release, no write to r7 occurs.
- Single alu request:
  - Stimulus: alu_wr_valid=1, dest 7, data 916, mem idle.
  - Required: alu_wr_ready=1 the same cycle. Next cycle reg_write=1, reg_write_dest=7, reg_write_data=916, wb_count=1.
- Contention with MAX_WAIT=3:
  - Stimulus: both valid every cycle, alu dest 5 data 11, mem dest 6 data 22.
  - Required: grant sequence M,M,M,A,M,M,M,A. conflict_count=8 after 8 cycles. wb_count=8.
- x0 suppression:
  - Stimulus: mem dest 0 data 0xFFFF_FFFF_FFFF_FFFF.
  - Required: mem_wr_ready=1. Next cycle reg_write=0 and wb_count unchanged. r0 reads 0.
- Hold:
  - Stimulus: wb_hold=1 for 4 cycles with both valid, starve_cnt=2.
  - Required: both readies 0, reg_write=0, starve_cnt stays 2, conflict_count unchanged.
  - After release: mem wins once, then alu is forced.
- Counter wrap:
  - Stimulus: preload wb_count to 0xFFFF via 65535 alu writes to r1, then one more write.
  - Required: wb_count=0x0000, and the register file still receives the write.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port.
// Two requesters compete for the port: the ALU result path and the
// load/memory result path. Memory has fixed priority. A starvation
// counter forces an ALU grant after MAX_WAIT consecutive lost
// contentions. The winning request is registered onto the reg_write
// outputs, which drive the register file directly. Writes to x0 can be
// dropped, and counts of performed writes and contended cycles are kept.
module reg_wb_arbiter #(
    parameter int MAX_WAIT           = 3,  // legal range 1..15
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_hold,
    input  logic        alu_wr_valid,
    input  logic [4:0]  alu_wr_dest,
    input  logic [63:0] alu_wr_data,
    output logic        alu_wr_ready,
    input  logic        mem_wr_valid,
    input  logic [4:0]  mem_wr_dest,
    input  logic [63:0] mem_wr_data,
    output logic        mem_wr_ready,
    output logic        reg_write,
    output logic [4:0]  reg_write_dest,
    output logic [63:0] reg_write_data,
    output logic [15:0] wb_count,
    output logic [15:0] conflict_count
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  starve_cnt;
    logic        force_alu;
    logic        grant_alu;
    logic        grant_mem;
    logic        grant_any;
    logic        contended;
    logic [4:0]  sel_dest;
    logic [63:0] sel_data;
    logic        sel_write_en;

    // Grant decision and selection of the winning destination and data.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        force_alu    = 1'b0;
        grant_alu    = 1'b0;
        grant_mem    = 1'b0;
        sel_dest     = mem_wr_dest;
        sel_data     = mem_wr_data;
        sel_write_en = 1'b1;

        force_alu = (starve_cnt == MAX_WAIT_C);
        if (!wb_hold) begin
            grant_alu = alu_wr_valid && (!mem_wr_valid || force_alu);
            grant_mem = mem_wr_valid && !grant_alu;
        end

        if (grant_alu) begin
            sel_dest = alu_wr_dest;
            sel_data = alu_wr_data;
        end

        if (ZERO_REG_HARDWIRED && (sel_dest == 5'd0)) begin
            sel_write_en = 1'b0;
        end
    end

    assign grant_any    = grant_alu || grant_mem;
    assign contended    = alu_wr_valid && mem_wr_valid && !wb_hold;
    assign alu_wr_ready = grant_alu;
    assign mem_wr_ready = grant_mem;

    // Starvation counter: counts consecutive contentions the ALU loses.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (!wb_hold) begin
            if (grant_alu || !alu_wr_valid) begin
                starve_cnt <= 4'd0;
            end else if (grant_mem && (starve_cnt != MAX_WAIT_C)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Output stage: register the granted write; address and data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write      <= 1'b0;
            reg_write_dest <= 5'd0;
            reg_write_data <= 64'd0;
        end else begin
            reg_write <= grant_any && sel_write_en;
            if (grant_any) begin
                reg_write_dest <= sel_dest;
                reg_write_data <= sel_data;
            end
        end
    end

    // Statistics: performed writes and contended cycles, both wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_count       <= 16'd0;
            conflict_count <= 16'd0;
        end else begin
            if (grant_any && sel_write_en) begin
                wb_count <= wb_count + 16'd1;
            end
            if (contended) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter with a small register-file model
// that receives the registered write outputs.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_hold;
    logic        alu_wr_valid;
    logic [4:0]  alu_wr_dest;
    logic [63:0] alu_wr_data;
    logic        alu_wr_ready;
    logic        mem_wr_valid;
    logic [4:0]  mem_wr_dest;
    logic [63:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        reg_write;
    logic [4:0]  reg_write_dest;
    logic [63:0] reg_write_data;
    logic [15:0] wb_count;
    logic [15:0] conflict_count;

    int          checks = 0;
    int          errors = 0;
    logic        a_rdy;
    logic        m_rdy;
    int          exp_wb;
    int          exp_cf;
    logic [7:0]  exp_alu_grant;
    logic [63:0] rf [32];

    reg_wb_arbiter #(.MAX_WAIT(3), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_hold        (wb_hold),
        .alu_wr_valid   (alu_wr_valid),
        .alu_wr_dest    (alu_wr_dest),
        .alu_wr_data    (alu_wr_data),
        .alu_wr_ready   (alu_wr_ready),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_dest    (mem_wr_dest),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_ready   (mem_wr_ready),
        .reg_write      (reg_write),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .wb_count       (wb_count),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    // Register file model: writes whatever the arbiter presents, x0 included.
    always @(posedge clk) begin
        if (reg_write) rf[reg_write_dest] <= reg_write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic hold,
                         input logic av, input logic [4:0] ad, input logic [63:0] adat,
                         input logic mv, input logic [4:0] md, input logic [63:0] mdat);
        wb_hold      = hold;
        alu_wr_valid = av;
        alu_wr_dest  = ad;
        alu_wr_data  = adat;
        mem_wr_valid = mv;
        mem_wr_dest  = md;
        mem_wr_data  = mdat;
    endtask

    // Called at a falling edge with inputs applied: capture readies, move to next falling edge.
    task automatic step();
        #1;
        a_rdy = alu_wr_ready;
        m_rdy = mem_wr_ready;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'd0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #2;
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_dest", 64'(reg_write_dest), 64'd0);
        check("rst_data", reg_write_data, 64'd0);
        check("rst_wb_count", 64'(wb_count), 64'd0);
        check("rst_conflict", 64'(conflict_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset mid-operation: a pending r3 write and a granted r7 request are both dropped.
        drive(1'b0, 1'b1, 5'd3, 64'd1, 1'b0, 5'd0, 64'd0);
        step();
        check("pre_rst_reg_write", 64'(reg_write), 64'd1);
        drive(1'b0, 1'b1, 5'd7, 64'd916, 1'b0, 5'd0, 64'd0);
        #1;
        check("midrst_alu_ready", 64'(alu_wr_ready), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_reg_write", 64'(reg_write), 64'd0);
        check("midrst_wb_count", 64'(wb_count), 64'd0);
        check("midrst_conflict", 64'(conflict_count), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        idle();
        check("midrst_no_write_r7", rf[7], 64'd0);
        check("midrst_no_write_r3", rf[3], 64'd0);
        check("midrst_reg_write_after", 64'(reg_write), 64'd0);
        exp_wb = 0;
        exp_cf = 0;

        // Single ALU request.
        drive(1'b0, 1'b1, 5'd7, 64'd916, 1'b0, 5'd0, 64'd0);
        step();
        exp_wb++;
        check("single_alu_ready", 64'(a_rdy), 64'd1);
        check("single_mem_ready", 64'(m_rdy), 64'd0);
        check("single_reg_write", 64'(reg_write), 64'd1);
        check("single_dest", 64'(reg_write_dest), 64'd7);
        check("single_data", reg_write_data, 64'd916);
        check("single_wb_count", 64'(wb_count), 64'(exp_wb));
        idle();
        check("single_rf_r7", rf[7], 64'd916);
        check("single_idle_reg_write", 64'(reg_write), 64'd0);
        check("single_idle_dest_hold", 64'(reg_write_dest), 64'd7);

        // Contention: grant order M,M,M,A,M,M,M,A.
        exp_alu_grant = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 5'd5, 64'd11, 1'b1, 5'd6, 64'd22);
            step();
            exp_wb++;
            exp_cf++;
            check($sformatf("cont%0d_alu_ready", i), 64'(a_rdy), 64'(exp_alu_grant[i]));
            check($sformatf("cont%0d_mem_ready", i), 64'(m_rdy), 64'(!exp_alu_grant[i]));
            check($sformatf("cont%0d_dest", i), 64'(reg_write_dest), exp_alu_grant[i] ? 64'd5 : 64'd6);
            check($sformatf("cont%0d_data", i), reg_write_data, exp_alu_grant[i] ? 64'd11 : 64'd22);
        end
        check("cont_conflict", 64'(conflict_count), 64'(exp_cf));
        check("cont_wb_count", 64'(wb_count), 64'(exp_wb));
        idle();
        check("cont_rf_r5", rf[5], 64'd11);
        check("cont_rf_r6", rf[6], 64'd22);

        // x0 suppression.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("x0_mem_ready", 64'(m_rdy), 64'd1);
        check("x0_reg_write", 64'(reg_write), 64'd0);
        check("x0_wb_count", 64'(wb_count), 64'(exp_wb));
        idle();
        check("x0_rf_r0", rf[0], 64'd0);

        // Hold with starve count at 2, then mem once and forced alu.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 5'd5, 64'd33, 1'b1, 5'd6, 64'd44);
            step();
            exp_wb++;
            exp_cf++;
            check($sformatf("prehold%0d_mem_ready", i), 64'(m_rdy), 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd5, 64'd33, 1'b1, 5'd6, 64'd44);
            step();
            check($sformatf("hold%0d_alu_ready", i), 64'(a_rdy), 64'd0);
            check($sformatf("hold%0d_mem_ready", i), 64'(m_rdy), 64'd0);
            check($sformatf("hold%0d_reg_write", i), 64'(reg_write), 64'd0);
        end
        check("hold_conflict", 64'(conflict_count), 64'(exp_cf));
        check("hold_wb_count", 64'(wb_count), 64'(exp_wb));
        drive(1'b0, 1'b1, 5'd5, 64'd33, 1'b1, 5'd6, 64'd44);
        step();
        exp_wb++;
        exp_cf++;
        check("rel0_mem_ready", 64'(m_rdy), 64'd1);
        check("rel0_alu_ready", 64'(a_rdy), 64'd0);
        step();
        exp_wb++;
        exp_cf++;
        check("rel1_alu_ready", 64'(a_rdy), 64'd1);
        check("rel1_dest", 64'(reg_write_dest), 64'd5);
        check("rel1_conflict", 64'(conflict_count), 64'(exp_cf));
        idle();

        // Counter wrap: fill wb_count to 0xFFFF with r1 writes, then one more.
        for (int i = exp_wb; i < 16'hFFFF; i++) begin
            drive(1'b0, 1'b1, 5'd1, 64'(i), 1'b0, 5'd0, 64'd0);
            step();
        end
        check("wrap_pre_wb_count", 64'(wb_count), 64'hFFFF);
        drive(1'b0, 1'b1, 5'd1, 64'hABCD, 1'b0, 5'd0, 64'd0);
        step();
        check("wrap_alu_ready", 64'(a_rdy), 64'd1);
        check("wrap_wb_count", 64'(wb_count), 64'd0);
        check("wrap_reg_write", 64'(reg_write), 64'd1);
        idle();
        check("wrap_rf_r1", rf[1], 64'hABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
